voice_allocator: RTL

Schedules the synth's shared voice channels among the debounced key inputs.
- Detects press/release edges per key and queues them as pending events.
- Services one event per clock: assigns a free voice on press, frees it on release, and steals the oldest voice when all are busy.
- Sits between the key debouncers and the tone generators; exposes status and counters on the peripheral bus (cs/addr/rd, combinational rdata).

---
 rtl/voice_allocator.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Voice allocator: queues key press/release edges and services one per clock onto NVOICES voice lanes.
// Optional build macro VOICE_STEAL_EN: steal the oldest voice when all are busy (otherwise drop the press).

module voice_lane #(
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             rel_i,
  input  logic [KEY_W-1:0] key_i,
`ifdef VOICE_STEAL_EN
  input  logic             bump_i,
  output logic [7:0]       age_o,
`endif
  output logic             gate_o,
  output logic [KEY_W-1:0] key_o,
  output logic             trig_o
);
  logic             gate_q, trig_q;
  logic [KEY_W-1:0] key_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_q <= 1'b0;
      key_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      trig_q <= load_i;
      if (load_i) begin
        gate_q <= 1'b1;
        key_q  <= key_i;
      end else if (rel_i) begin
        gate_q <= 1'b0;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [7:0] age_q;
  // Age counts presses seen while this voice was busy; saturates so the oldest stays oldest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  age_q <= '0;
    else if (load_i)                             age_q <= '0;
    else if (bump_i && gate_q && age_q != 8'hFF) age_q <= age_q + 8'd1;
  end
  assign age_o = age_q;
`endif

  assign gate_o = gate_q;
  assign key_o  = key_q;
  assign trig_o = trig_q;
endmodule

module voice_allocator #(
  parameter int NKEYS   = 4,
  parameter int NVOICES = 2,
  parameter int KEY_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NKEYS-1:0]         key_state,
  input  logic                     cs,
  input  logic [3:0]               addr,
  input  logic                     rd,
  output logic [31:0]              rdata,
  output logic [NVOICES-1:0]       voice_gate,
  output logic [NVOICES*KEY_W-1:0] voice_key,
  output logic [NVOICES-1:0]       voice_trig
);
  logic [NKEYS-1:0] key_prev_q, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
  logic [NKEYS-1:0] rise, fall, off_oh, on_oh, clr_on, clr_off;
  logic [KEY_W-1:0] off_k, on_k;
  logic [NVOICES-1:0] holds, free_oh, load, rel;
  logic [NVOICES-1:0][KEY_W-1:0] vkey;
  logic [CNT_W-1:0] drop_cnt_q;
  logic drop_inc;

`ifdef VOICE_STEAL_EN
  logic [NVOICES-1:0][7:0] age;
  logic [NVOICES-1:0] old_oh;
  logic [7:0] best_age;
  logic [CNT_W-1:0] steal_cnt_q;
  logic bump, steal_inc;
`endif

  assign rise    = key_state & ~key_prev_q;
  assign fall    = ~key_state & key_prev_q;
  assign off_oh  = pend_off_q & (~pend_off_q + 1'b1);
  assign on_oh   = pend_on_q & (~pend_on_q + 1'b1);
  assign free_oh = ~voice_gate & (voice_gate + 1'b1);

  for (genvar v = 0; v < NVOICES; v++) begin : g_lane
    assign holds[v] = voice_gate[v] && (vkey[v] == off_k);
    voice_lane #(.KEY_W(KEY_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load_i (load[v]),
      .rel_i  (rel[v]),
      .key_i  (on_k),
`ifdef VOICE_STEAL_EN
      .bump_i (bump),
      .age_o  (age[v]),
`endif
      .gate_o (voice_gate[v]),
      .key_o  (vkey[v]),
      .trig_o (voice_trig[v])
    );
  end
  assign voice_key = vkey;

  // Descending scans leave the lowest matching index as the winner.
  always_comb begin
    off_k = '0;
    on_k  = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (pend_off_q[k]) off_k = KEY_W'(k);
      if (pend_on_q[k])  on_k  = KEY_W'(k);
    end
  end

`ifdef VOICE_STEAL_EN
  always_comb begin
    old_oh   = '0;
    best_age = '0;
    for (int v = NVOICES - 1; v >= 0; v--) begin
      if (age[v] >= best_age) begin
        best_age = age[v];
        old_oh   = NVOICES'(1) << v;
      end
    end
  end
`endif

  always_comb begin
    clr_on   = '0;
    clr_off  = '0;
    load     = '0;
    rel      = '0;
    drop_inc = 1'b0;
`ifdef VOICE_STEAL_EN
    bump      = 1'b0;
    steal_inc = 1'b0;
`endif
    if (|pend_off_q) begin
      clr_off = off_oh;
      // A press+release that never reached a voice vanishes without touching the voices.
      if ((|(off_oh & pend_on_q)) && !(|holds)) clr_on = off_oh;
      else                                      rel    = holds;
    end else if (|pend_on_q) begin
      clr_on = on_oh;
      if (|free_oh) begin
        load = free_oh;
`ifdef VOICE_STEAL_EN
        bump = 1'b1;
`endif
      end else begin
`ifdef VOICE_STEAL_EN
        load      = old_oh;
        bump      = 1'b1;
        steal_inc = 1'b1;
`else
        drop_inc  = 1'b1;
`endif
      end
    end
  end

  assign pend_on_d  = (pend_on_q | rise) & ~clr_on;
  assign pend_off_d = (pend_off_q | fall) & ~clr_off;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev_q <= '0;
      pend_on_q  <= '0;
      pend_off_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      key_prev_q <= key_state;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      drop_cnt_q <= drop_cnt_q + CNT_W'(drop_inc);
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) steal_cnt_q <= '0;
    else        steal_cnt_q <= steal_cnt_q + CNT_W'(steal_inc);
  end
`endif

  always_comb begin
    rdata = '0;
    if (cs && rd) begin
      case (addr)
        4'h0:    rdata = 32'(voice_gate);
        4'h1:    rdata = 32'(voice_key);
`ifdef VOICE_STEAL_EN
        4'h2:    rdata = 32'(steal_cnt_q);
`else
        4'h2:    rdata = 32'h0;
`endif
        4'h3:    rdata = 32'(drop_cnt_q);
        4'h4:    rdata = 32'({pend_off_q, pend_on_q});
        default: rdata = 32'hDEADBEEF;
      endcase
    end
  end
endmodule
